qrd_pipe_scheduler: RTL and testbench

Sequences frames of H matrix and Y vector through the free-running, non-stallable Givens-rotation QR pipeline.
- Accepts frames from an upstream requester over valid/ready.
- Issues each frame into the pipeline and tracks every in-flight frame with a valid/tag shift register.
- Captures each result when it exits the pipeline, into a small output FIFO with valid/ready.
- Credit-gated issue ensures results are never dropped, even though the pipeline cannot be stalled.

---
 rtl/qrd_pipe_scheduler.sv | 131 +++++++++++++
 tb/tb_qrd_pipe_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qrd_pipe_scheduler.sv
// qrd_pipe_scheduler: credit-gated frame sequencer for a free-running Givens QR pipeline.
// Define QRD_SCHED_STATS_EN to enable the saturating stat_frames/stat_stalls counters.
`ifndef WL
`define WL 16
`endif
module qrd_pipe_scheduler #(
  parameter int N = 8,
  parameter int LAT = 21,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`WL*N*N-1:0]    in_h,
  input  logic [`WL*N-1:0]      in_y,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [`WL*N*N-1:0]    pipe_h_o,
  output logic [`WL*N-1:0]      pipe_y_o,
  input  logic [`WL*N*N-1:0]    pipe_h_i,
  input  logic [`WL*N-1:0]      pipe_y_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`WL*N*N-1:0]    out_h,
  output logic [`WL*N-1:0]      out_y,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_stalls
);
  localparam int HW = `WL*N*N;
  localparam int YW = `WL*N;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;
  state_t r_state, w_next;
  // One extra stage so capture lands on the edge after the pipeline result appears.
  logic [LAT:0]     r_vld;
  logic [TAG_W-1:0] r_tag [LAT+1];
  logic [CW-1:0]    r_inflight, r_cnt, w_inflight, w_cnt;
  logic [PW-1:0]    r_wp, r_rp;
  logic [HW-1:0]    r_mem_h [FIFO_DEPTH];
  logic [YW-1:0]    r_mem_y [FIFO_DEPTH];
  logic [TAG_W-1:0] r_mem_t [FIFO_DEPTH];
  logic [HW-1:0]    r_pipe_h;
  logic [YW-1:0]    r_pipe_y;
  logic             r_in_ready, r_busy, w_fire, w_cap, w_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_fire     = in_valid && r_in_ready;
  assign w_cap      = r_vld[LAT];
  assign w_pop      = out_valid && out_ready;
  assign w_inflight = r_inflight + CW'(w_fire) - CW'(w_cap);
  assign w_cnt      = r_cnt + CW'(w_cap) - CW'(w_pop);
  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign pipe_h_o   = r_pipe_h;
  assign pipe_y_o   = r_pipe_y;
  assign out_valid  = r_cnt != '0;
  assign out_h      = out_valid ? r_mem_h[r_rp] : '0;
  assign out_y      = out_valid ? r_mem_y[r_rp] : '0;
  assign out_tag    = out_valid ? r_mem_t[r_rp] : '0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= RUN;
    else r_state <= w_next;

  always_comb
    w_next = r_state == RUN   ? (flush_req ? DRAIN : RUN) :
             r_state == DRAIN ? ((r_inflight == '0 && r_cnt == '0) ? DONE : DRAIN) :
             (flush_req ? HOLD : RUN);

  always_comb flush_done = r_state == DONE;

  // in_ready and busy are registered from next-cycle counts, so a pop never grants same-cycle credit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vld      <= '0;
      for (int i = 0; i <= LAT; i++) r_tag[i] <= '0;
      r_pipe_h   <= '0;
      r_pipe_y   <= '0;
      r_inflight <= '0;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vld      <= {r_vld[LAT-1:0], w_fire};
      r_tag[0]   <= w_fire ? in_tag : '0;
      for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
      r_pipe_h   <= w_fire ? in_h : '0;
      r_pipe_y   <= w_fire ? in_y : '0;
      r_inflight <= w_inflight;
      r_cnt      <= w_cnt;
      r_wp       <= w_cap ? inc(r_wp) : r_wp;
      r_rp       <= w_pop ? inc(r_rp) : r_rp;
      r_in_ready <= w_next == RUN && (32'(w_inflight) + 32'(w_cnt) < FIFO_DEPTH);
      r_busy     <= w_inflight != '0 || w_cnt != '0;
    end

  always_ff @(posedge clk)
    if (w_cap) begin
      r_mem_h[r_wp] <= pipe_h_i;
      r_mem_y[r_wp] <= pipe_y_i;
      r_mem_t[r_wp] <= r_tag[LAT];
    end

`ifdef QRD_SCHED_STATS_EN
  logic [15:0] r_stat_frames, r_stat_stalls;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_stat_frames <= '0;
      r_stat_stalls <= '0;
    end else begin
      r_stat_frames <= (w_fire && r_stat_frames != 16'hFFFF) ? r_stat_frames + 1'b1 : r_stat_frames;
      r_stat_stalls <= (in_valid && !r_in_ready && r_stat_stalls != 16'hFFFF) ? r_stat_stalls + 1'b1 : r_stat_stalls;
    end
  assign stat_frames = r_stat_frames;
  assign stat_stalls = r_stat_stalls;
`else
  assign stat_frames = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_qrd_pipe_scheduler.sv
// tb_qrd_pipe_scheduler: scoreboard bench; a LAT-cycle delay line with an XOR mask stands in for the QR pipeline.
`ifndef WL
`define WL 16
`endif
module tb_qrd_pipe_scheduler;
  localparam int N = 8;
  localparam int LAT = 21;
  localparam int FD = 4;
  localparam int TAG_W = 4;
  localparam int HW = `WL*N*N;
  localparam int YW = `WL*N;
  localparam logic [HW-1:0] MASK_H = {(HW/16){16'h5A3C}};
  localparam logic [YW-1:0] MASK_Y = {(YW/16){16'hC3A5}};

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush_req = 1'b0;
  logic in_ready, out_valid, flush_done, busy;
  logic [HW-1:0] in_h = '0, pipe_h_o, pipe_h_i, out_h;
  logic [YW-1:0] in_y = '0, pipe_y_o, pipe_y_i, out_y;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [15:0] stat_frames, stat_stalls;

  qrd_pipe_scheduler #(.N(N), .LAT(LAT), .FIFO_DEPTH(FD), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_h(in_h), .in_y(in_y),
    .in_tag(in_tag), .pipe_h_o(pipe_h_o), .pipe_y_o(pipe_y_o), .pipe_h_i(pipe_h_i), .pipe_y_i(pipe_y_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h), .out_y(out_y), .out_tag(out_tag),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .stat_frames(stat_frames), .stat_stalls(stat_stalls));

  always #5 clk = ~clk;

  logic [HW-1:0] ph_d [LAT];
  logic [YW-1:0] py_d [LAT];
  always @(posedge clk) begin
    ph_d[0] <= pipe_h_o;
    py_d[0] <= pipe_y_o;
    for (int k = 1; k < LAT; k++) begin
      ph_d[k] <= ph_d[k-1];
      py_d[k] <= py_d[k-1];
    end
  end
  assign pipe_h_i = ph_d[LAT-1] ^ MASK_H;
  assign pipe_y_i = py_d[LAT-1] ^ MASK_Y;

  typedef struct {
    logic [HW-1:0] h;
    logic [YW-1:0] y;
    logic [TAG_W-1:0] tag;
    int e;
  } frame_t;
  typedef struct {
    logic v;
    logic rdy;
    logic exp_ir;
    logic exp_ov;
  } vec_t;

  frame_t q[$];
  int checks = 0, failures = 0;
  int edge_n = 0, mode = 0, done_cnt = 0, fires = 0, pops = 0;
  int m_sf = 0, m_ss = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [HW-1:0] a, input logic [HW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got ..%h expected ..%h", nm, a[127:0], e[127:0]);
    end
  endtask

  function automatic logic [HW-1:0] rnd_h();
    logic [HW-1:0] r;
    for (int i = 0; i < HW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [YW-1:0] rnd_y();
    logic [YW-1:0] r;
    for (int i = 0; i < YW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_stats();
`ifdef QRD_SCHED_STATS_EN
    chk("stat_frames", stat_frames, 64'(m_sf));
    chk("stat_stalls", stat_stalls, 64'(m_ss));
`else
    chk("stat_frames", stat_frames, 0);
    chk("stat_stalls", stat_stalls, 0);
`endif
  endtask

  // mode: 0 accepting, 1 draining, 2 drain complete (pulse), 3 waiting for flush_req to fall.
  task automatic step(input logic v, input logic rdy, input logic fr, input logic [TAG_W-1:0] tg,
                      output logic ir_s, output logic ov_s);
    frame_t f;
    logic eir, eov, fire, pop;
    int nmode;
    f.h = rnd_h();
    f.y = rnd_y();
    f.tag = tg;
    f.e = edge_n + 1;
    in_valid = v; out_ready = rdy; flush_req = fr; in_h = f.h; in_y = f.y; in_tag = tg;
    #1;
    eir = mode == 0 && q.size() < FD;
    eov = q.size() > 0 && edge_n >= q[0].e + LAT + 1;
    ir_s = in_ready;
    ov_s = out_valid;
    chk("in_ready", in_ready, 64'(eir));
    chk("out_valid", out_valid, 64'(eov));
    nmode = mode == 0 ? (fr ? 1 : 0) : mode == 1 ? (q.size() == 0 ? 2 : 1) : (fr ? 3 : 0);
    fire = v && eir;
    pop = eov && rdy;
    if (pop) begin
      chk("out_tag", out_tag, 64'(q[0].tag));
      chkw("out_h", out_h, q[0].h ^ MASK_H);
      chkw("out_y", HW'(out_y), HW'(q[0].y ^ MASK_Y));
      void'(q.pop_front());
      pops++;
    end
    if (v && !eir && m_ss < 16'hFFFF) m_ss++;
    if (fire) begin
      q.push_back(f);
      fires++;
      if (m_sf < 16'hFFFF) m_sf++;
    end
    @(posedge clk);
    edge_n++;
    mode = nmode;
    #1;
    chkw("pipe_h_o", pipe_h_o, fire ? f.h : '0);
    chkw("pipe_y_o", HW'(pipe_y_o), fire ? HW'(f.y) : '0);
    chk("busy", busy, 64'(q.size() != 0));
    chk("flush_done", flush_done, 64'(mode == 2));
    if (flush_done) done_cnt++;
    check_stats();
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a, b;
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0, a, b);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush_req = 1'b0;
    #1;
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_flush_done"}, flush_done, 0);
    chk({nm, "_out_tag"}, out_tag, 0);
    chkw({nm, "_pipe_h_o"}, pipe_h_o, '0);
    chkw({nm, "_out_h"}, out_h, '0);
    chk({nm, "_stat_frames"}, stat_frames, 0);
    q.delete();
    mode = 0; m_sf = 0; m_ss = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [8];
    logic a, b;
    int fe, cap0, fire0, ntag;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, logic'(i < FD), 1'b0};

    do_reset("rst0");

    // single frame latency
    step(1'b1, 1'b0, 1'b0, 4'd3, a, b);
    fe = edge_n;
    for (int k = 0; k < 3*LAT && !out_valid; k++) step(1'b0, 1'b0, 1'b0, '0, a, b);
    chk("latency", 64'(edge_n - fe), 64'(LAT + 1));
    chk("single_tag", out_tag, 3);
    step(1'b0, 1'b1, 1'b0, '0, a, b);
    chk("busy_after_pop", busy, 0);

    // back-to-back fill with downstream stalled
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].rdy, 1'b0, TAG_W'(i), a, b);
      chk("tbl_in_ready", a, 64'(tbl[i].exp_ir));
      chk("tbl_out_valid", b, 64'(tbl[i].exp_ov));
    end
    idle(LAT + 4, 1'b0);
    chk("fifo_full_count", 64'(q.size()), 64'(FD));
    idle(FD, 1'b1);
    for (int i = 0; i < FD; i++) step(1'b1, 1'b0, 1'b0, TAG_W'(FD + i), a, b);
    idle(LAT + 10, 1'b1);

    // steady state push/pop with in-order tags
    ntag = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, TAG_W'(ntag), a, b);
      if (a) ntag++;
    end
    idle(LAT + 10, 1'b1);

    // bubbles on alternate cycles
    fire0 = fires; cap0 = pops;
    for (int i = 0; i < 40; i++) step(logic'(i % 2 == 0), 1'b1, 1'b0, TAG_W'(i), a, b);
    idle(LAT + 10, 1'b1);
    chk("bubble_captures", 64'(pops - cap0), 64'(fires - fire0));

    // flush with three frames in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, TAG_W'(i), a, b);
    done_cnt = 0;
    for (int k = 0; k < 3*LAT && done_cnt == 0; k++) step(1'b1, 1'b1, 1'b1, '0, a, b);
    idle(0, 1'b1);
    step(1'b1, 1'b1, 1'b1, '0, a, b);
    step(1'b1, 1'b1, 1'b1, '0, a, b);
    chk("flush_pulses", 64'(done_cnt), 1);
    chk("ready_held_low", in_ready, 0);
    step(1'b0, 1'b1, 1'b0, '0, a, b);
    chk("ready_after_flush", in_ready, 1);

    // reset with two frames in flight and one buffered
    step(1'b1, 1'b0, 1'b0, 4'd1, a, b);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd2, a, b);
    step(1'b1, 1'b0, 1'b0, 4'd3, a, b);
    for (int k = 0; k < 3*LAT && !out_valid; k++) step(1'b0, 1'b0, 1'b0, '0, a, b);
    chk("pre_reset_buffered", out_valid, 1);
    #2;
    do_reset("rst_mid");
    cap0 = 0;
    for (int i = 0; i < 2*LAT; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, a, b);
      if (b) cap0++;
    end
    chk("no_stale_result", 64'(cap0), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 49) == 0), TAG_W'($urandom), a, b);
    idle(LAT + 10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
